note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Pattern sequencer that drives the synth voice's control inputs.
- Steps through a programmable table of notes and, for each step, produces `osc_count`, a `trig` gate held for whole `clk_adsr` periods, and a `latch_cfg` window.
- Sits directly upstream of the synth voice on the same 20.48 MHz `clk`.
- Pattern is written through a simple register-write port by the host interface.

Parameters:
- STEPS, 8, number of pattern entries (power of two, 2..16).
- TICK_DIV, 262144, `clk` cycles per tick. Default equals one `clk_adsr` period (20480000/78.125).

Ports:
- clk  in  1  system clock, 20.48 MHz.
- arst  in  1  asynchronous active-high reset.
- run  in  1  level; 1 = sequencer plays, 0 = stopped.
- step_len  in  8  ticks per step; values 0 and 1 are treated as 2.
- last_step  in  $clog2(STEPS)  index of the final step before wrap to 0.
- wr_en  in  1  pattern write strobe, one `clk`.
- wr_addr  in  $clog2(STEPS)  pattern entry index.
- wr_data  in  16  [11:0] osc_count, [15:12] gate ticks G (0 = rest).
- osc_count  out  12  oscillator period for the current step.
- trig  out  1  note gate to the voice.
- latch_cfg  out  1  config latch window.
- step_idx  out  $clog2(STEPS)  current step.
- busy  out  1  1 while not IDLE.

Behaviour:
- **Reset (`arst`=1, async):** all outputs 0, state IDLE, tick counter 0, tick-in-step counter 0. Pattern RAM is cleared to 0.
- **Pattern RAM:** STEPS x 16 registers, written on the `clk` edge with `wr_en`=1. Writes are accepted in any state.
- **Tick generator:** counter 0..TICK_DIV-1, running only when not IDLE. Asserts a 1-cycle internal tick when it reaches TICK_DIV-1, then wraps to 0.
- **Effective lengths:** L = max(step_len, 2). Gate length E = min(G, L-1). This guarantees at least 1 tick of `trig` low between steps, so the voice sees a retrigger edge after its 2-stage `clk_adsr` synchroniser.
- **States:** IDLE, GATE, GAP.
- **IDLE -> step entry:** on the first `clk` with `run`=1, go to step 0.
- **Step entry** (registered on the entry edge, for step s):
  - `step_idx`<=s, `osc_count`<=RAM[s], tick-in-step counter<=0, tick counter<=0, `latch_cfg`<=1.
  - E>0: state GATE, `trig`<=1. E=0: state GAP, `trig`<=0.
  - RAM read bypass: if `wr_en` hits `wr_addr`==s on the entry edge, `wr_data` is used.
- **Counting:** each tick increments the tick-in-step counter (0..L-1).
- **`latch_cfg`:** deasserts on the first tick of the step. It is high for exactly TICK_DIV cycles, i.e. one full `clk_adsr` period.
- **GATE -> GAP:** when the counter reaches E on a tick, `trig`<=0.
- **Step end:** on the tick where the counter equals L-1, enter the next step.
  - Next step = s+1, or 0 if s>=`last_step`.
  - `last_step` and `step_len` are sampled at step entry for L and at step end for wrap. Lowering `last_step` below s mid-step wraps to 0 at step end.
- **Pattern writes mid-step:** a write to the current step does not change `osc_count` or the gate until that step is next entered.
- **Stop:** `run`=0 in any non-IDLE state; next edge goes to IDLE with `trig`<=0, `latch_cfg`<=0, `busy`<=0, counters cleared. `osc_count` and `step_idx` hold.
- **Restart:** `run` 0->1 always restarts at step 0, with no partial tick carried over.
- **Timing:** `busy`=1 in GATE/GAP. Outputs are registered with 1-cycle latency from `run`.
- **Simultaneous events:** `run`=0 has priority over tick/step end. `arst` overrides all.

Test Plan (TICK_DIV=4, STEPS=8):
1. **Basic step.** Reset, write RAM[0]=0x3123 (G=3, count 0x123), `last_step`=0, `step_len`=5, `run`=1.
   - `osc_count`=0x123 one cycle after `run`.
   - `trig` high 12 cycles then low 8; `latch_cfg` high first 4 cycles.
   - Pattern repeats every 20 cycles, with a `latch_cfg` pulse each step.
2. **Clamping.** G=15, `step_len`=1 -> L=2, E=1: `trig` high 4, low 4, period 8.
   - G=0 (rest) -> `trig` stays 0 while `osc_count` and `latch_cfg` still update.
3. **Wrap.** `last_step`=2, three distinct entries -> `step_idx` sequence 0,1,2,0,… with matching `osc_count`.
   - Set `last_step`=0 while at step 2 -> next step 0.
4. **Write interaction.** Write to the current step mid-step -> no output change until re-entry.
   - Write to the next step on its entry edge -> new value appears (bypass).
5. **Stop/restart.** `run`=0 mid-GATE -> `trig`=0, `busy`=0 next cycle, `osc_count` holds.
   - `run`=1 -> step 0 restarts with full tick timing.
6. **Async reset.** `arst` pulse mid-step, asserted between clock edges -> all outputs 0 immediately.
   - RAM cleared; `run`=1 afterwards gives `osc_count`=0, `trig`=0.

Source files
------------

// File: rtl/note_sequencer_if.sv
// Pattern write port between the host interface and the note sequencer.
//
// Handshake: wr_en is a single-cycle strobe qualified by clk. There is no
// ready signal because the sequencer accepts a write on every edge where
// wr_en=1, whatever state it is in. wr_addr and wr_data only matter while
// wr_en=1. The host drives through the master modport and the sequencer
// listens through the slave modport.
interface note_sequencer_if #(
  parameter int STEPS = 8
);
  localparam int AW = $clog2(STEPS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/note_sequencer.sv
// Note sequencer: plays a STEPS-entry pattern into the synth voice.
// Each step sets osc_count, holds trig for E whole ticks and latch_cfg for
// the first tick, and lasts L ticks. One tick is TICK_DIV clk cycles, which
// by default matches one clk_adsr period. Outputs are all registered.
module note_sequencer #(
  parameter  int STEPS    = 8,
  parameter  int TICK_DIV = 262144,
  localparam int AW       = $clog2(STEPS),
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          run,
  input  logic [7:0]    step_len,
  input  logic [AW-1:0] last_step,
  note_sequencer_if.slave wr_bus,
  output logic [11:0]   osc_count,
  output logic          trig,
  output logic          latch_cfg,
  output logic [AW-1:0] step_idx,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // Registered state
  state_t        state_q,    state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    tis_q,      tis_d;      // ticks elapsed in the current step
  logic [7:0]    len_q,      len_d;      // L captured at step entry
  logic [3:0]    gate_q,     gate_d;     // E captured at step entry
  logic [11:0]   osc_q,      osc_d;
  logic          trig_q,     trig_d;
  logic          latch_q,    latch_d;
  logic [AW-1:0] step_q,     step_d;

  logic [15:0]   ram_q [STEPS];

  // Step-entry helpers
  logic          tick;
  logic          step_end;
  logic [AW-1:0] next_step;
  logic [AW-1:0] entry_addr;
  logic [15:0]   entry_word;
  logic [3:0]    entry_g;
  logic [3:0]    entry_e;
  logic [7:0]    eff_len;
  logic [7:0]    len_m1;
  logic          do_entry;

  // Pattern RAM: cleared by reset, written whenever the strobe is high
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < STEPS; i++) begin
        ram_q[i] <= '0;
      end
    end else if (wr_bus.wr_en) begin
      ram_q[wr_bus.wr_addr] <= wr_bus.wr_data;
    end
  end

  // Tick strobe, step end, wrap and the entry word with write bypass
  always_comb begin
    tick      = (state_q != ST_IDLE) && (tick_cnt_q == TICK_LAST);
    step_end  = tick && (tis_q == (len_q - 8'd1));
    next_step = (step_q >= last_step) ? '0 : (step_q + AW'(1));

    // From IDLE we always start at step 0; otherwise the entry is the next step.
    entry_addr = (state_q == ST_IDLE) ? '0 : next_step;
    if (wr_bus.wr_en && (wr_bus.wr_addr == entry_addr)) begin
      entry_word = wr_bus.wr_data;
    end else begin
      entry_word = ram_q[entry_addr];
    end

    // L = max(step_len, 2); E = min(G, L-1) keeps one low tick before the next note.
    eff_len = (step_len < 8'd2) ? 8'd2 : step_len;
    len_m1  = eff_len - 8'd1;
    entry_g = entry_word[15:12];
    if ({4'b0000, entry_g} > len_m1) begin
      entry_e = len_m1[3:0];
    end else begin
      entry_e = entry_g;
    end
  end

  // Next-state and output logic for IDLE / GATE / GAP
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    tis_d      = tis_q;
    len_d      = len_q;
    gate_d     = gate_q;
    osc_d      = osc_q;
    trig_d     = trig_q;
    latch_d    = latch_q;
    step_d     = step_q;
    do_entry   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        tis_d      = '0;
        if (run) begin
          do_entry = 1'b1;
        end
      end

      ST_GATE, ST_GAP: begin
        if (!run) begin
          // Stop wins over any tick or step end; osc_count and step_idx hold.
          state_d    = ST_IDLE;
          trig_d     = 1'b0;
          latch_d    = 1'b0;
          tick_cnt_d = '0;
          tis_d      = '0;
        end else if (tick) begin
          if (step_end) begin
            do_entry = 1'b1;
          end else begin
            tick_cnt_d = '0;
            tis_d      = tis_q + 8'd1;
            latch_d    = 1'b0;
            if ((state_q == ST_GATE) && ((tis_q + 8'd1) == {4'b0000, gate_q})) begin
              trig_d  = 1'b0;
              state_d = ST_GAP;
            end
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        trig_d  = 1'b0;
        latch_d = 1'b0;
      end
    endcase

    // Step entry restarts all timing and captures the step's parameters.
    if (do_entry) begin
      step_d     = entry_addr;
      osc_d      = entry_word[11:0];
      len_d      = eff_len;
      gate_d     = entry_e;
      tis_d      = '0;
      tick_cnt_d = '0;
      latch_d    = 1'b1;
      if (entry_e != 4'd0) begin
        state_d = ST_GATE;
        trig_d  = 1'b1;
      end else begin
        state_d = ST_GAP;
        trig_d  = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      tis_q      <= '0;
      len_q      <= 8'd2;
      gate_q     <= '0;
      osc_q      <= '0;
      trig_q     <= 1'b0;
      latch_q    <= 1'b0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      tis_q      <= tis_d;
      len_q      <= len_d;
      gate_q     <= gate_d;
      osc_q      <= osc_d;
      trig_q     <= trig_d;
      latch_q    <= latch_d;
      step_q     <= step_d;
    end
  end

  assign osc_count = osc_q;
  assign trig      = trig_q;
  assign latch_cfg = latch_q;
  assign step_idx  = step_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer with TICK_DIV=4, STEPS=8.
// The reference model tracks, per step, the number of clk cycles since
// entry and derives trig/latch_cfg/step end from plain arithmetic on it.
module tb_note_sequencer;

  localparam int STEPS = 8;
  localparam int TD    = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  step_len = 8'd2;
  logic [2:0]  last_step = 3'd0;
  logic [11:0] osc_count;
  logic        trig;
  logic        latch_cfg;
  logic [2:0]  step_idx;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  note_sequencer_if #(.STEPS(STEPS)) wr_bus ();

  note_sequencer #(.STEPS(STEPS), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .arst      (arst),
    .run       (run),
    .step_len  (step_len),
    .last_step (last_step),
    .wr_bus    (wr_bus),
    .osc_count (osc_count),
    .trig      (trig),
    .latch_cfg (latch_cfg),
    .step_idx  (step_idx),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_ram [STEPS];
  bit          m_active;
  int          m_s;
  int          m_c;     // clk cycles since this step was entered
  int          m_L;
  int          m_E;
  int          m_osc;

  task automatic model_reset();
    for (int i = 0; i < STEPS; i++) m_ram[i] = '0;
    m_active = 0; m_s = 0; m_c = 0; m_L = 2; m_E = 0; m_osc = 0;
  endtask

  task automatic model_enter(input int s);
    logic [15:0] w;
    int g;
    w = (wr_bus.wr_en && (int'(wr_bus.wr_addr) == s)) ? wr_bus.wr_data : m_ram[s];
    g = int'(w[15:12]);
    m_s = s;
    m_osc = int'(w[11:0]);
    m_L = (int'(step_len) < 2) ? 2 : int'(step_len);
    m_E = (g < m_L - 1) ? g : m_L - 1;
    m_c = 0;
    m_active = 1;
  endtask

  // Predicts the effect of the coming rising edge from the current inputs.
  task automatic model_step();
    if (!m_active) begin
      if (run) model_enter(0);
    end else if (!run) begin
      m_active = 0;
    end else if (m_c == m_L * TD - 1) begin
      model_enter((m_s >= int'(last_step)) ? 0 : m_s + 1);
    end else begin
      m_c++;
    end
    if (wr_bus.wr_en) m_ram[wr_bus.wr_addr] = wr_bus.wr_data;
  endtask

  task automatic compare_all();
    check("osc_count", 32'(osc_count), 32'(m_osc));
    check("step_idx",  32'(step_idx),  32'(m_s));
    check("busy",      32'(busy),      32'(m_active));
    check("trig",      32'(trig),      32'(m_active && (m_c < m_E * TD)));
    check("latch_cfg", 32'(latch_cfg), 32'(m_active && (m_c < TD)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_clk();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  task automatic write_word(input int addr, input logic [15:0] data);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = 3'(addr);
    wr_bus.wr_data = data;
    tick_clk();
    wr_bus.wr_en   = 1'b0;
  endtask

  task automatic count_outputs(input int n, output int trig_hi, output int latch_hi);
    trig_hi = 0; latch_hi = 0;
    for (int i = 0; i < n; i++) begin
      tick_clk();
      trig_hi  += int'(trig);
      latch_hi += int'(latch_cfg);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int th, lh, guard;
    logic [11:0] held;
    wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    compare_all();
    arst = 1'b0;

    // Basic step: G=3, L=5 -> trig 12 high / 8 low, latch 4 per 20 cycles.
    write_word(0, 16'h3123);
    last_step = 3'd0; step_len = 8'd5; run = 1'b1;
    tick_clk();
    check("basic_osc", 32'(osc_count), 32'h123);
    count_outputs(39, th, lh);
    check("basic_trig_cnt", 32'(th + 1), 32'd24);
    check("basic_latch_cnt", 32'(lh + 1), 32'd8);

    // Clamping: G=15 with step_len=1 -> L=2, E=1.
    run = 1'b0; tick_clk();
    write_word(0, 16'hF0AA);
    step_len = 8'd1; run = 1'b1;
    count_outputs(16, th, lh);
    check("clamp_trig_cnt", 32'(th), 32'd8);
    check("clamp_latch_cnt", 32'(lh), 32'd8);
    // Rest note written mid-step takes effect on the next entry.
    write_word(0, 16'h0055);
    run_cycles(16);
    check("rest_osc", 32'(osc_count), 32'h055);
    count_outputs(8, th, lh);
    check("rest_trig_cnt", 32'(th), 32'd0);
    check("rest_latch_cnt", 32'(lh), 32'd4);

    // Wrap over three entries, then lower last_step while at step 2.
    run = 1'b0; tick_clk();
    write_word(0, 16'h2111);
    write_word(1, 16'h1222);
    write_word(2, 16'h3333);
    last_step = 3'd2; step_len = 8'd3; run = 1'b1;
    run_cycles(40);
    guard = 0;
    while (!(m_active && m_s == 2) && guard < 100) begin tick_clk(); guard++; end
    check("wait_step2_timeout", 32'(guard < 100), 32'd1);
    last_step = 3'd0;
    guard = 0;
    while (m_s == 2 && guard < 100) begin tick_clk(); guard++; end
    check("wrap_low_timeout", 32'(guard < 100), 32'd1);
    check("wrap_low_idx", 32'(step_idx), 32'd0);
    check("wrap_low_osc", 32'(osc_count), 32'h111);

    // Write interaction: current step write holds, next-step entry write bypasses.
    last_step = 3'd2;
    guard = 0;
    while (m_c != 2 && guard < 100) begin tick_clk(); guard++; end
    held = osc_count;
    write_word(m_s, 16'h1DEF);
    run_cycles(3);
    check("hold_on_write", 32'(osc_count), 32'(held));
    guard = 0;
    while (m_c != m_L * TD - 1 && guard < 100) begin tick_clk(); guard++; end
    check("entry_wait_timeout", 32'(guard < 100), 32'd1);
    write_word((m_s >= int'(last_step)) ? 0 : m_s + 1, 16'h2ABC);
    check("bypass_osc", 32'(osc_count), 32'hABC);
    check("bypass_trig", 32'(trig), 32'd1);

    // Stop mid-GATE and restart with full timing.
    run = 1'b0; tick_clk();
    write_word(0, 16'h4321);
    last_step = 3'd0; step_len = 8'd6; run = 1'b1;
    run_cycles(2);
    run = 1'b0; tick_clk();
    check("stop_trig", 32'(trig), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_osc_hold", 32'(osc_count), 32'h321);
    run = 1'b1;
    count_outputs(24, th, lh);
    check("restart_trig_cnt", 32'(th), 32'd16);
    check("restart_latch_cnt", 32'(lh), 32'd4);

    // Async reset between edges clears outputs at once and the RAM.
    run_cycles(5);
    #2 arst = 1'b1;
    #1;
    check("arst_osc",   32'(osc_count), 32'd0);
    check("arst_trig",  32'(trig),      32'd0);
    check("arst_latch", 32'(latch_cfg), 32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_idx",   32'(step_idx),  32'd0);
    model_reset();
    #1 arst = 1'b0;
    run_cycles(10);
    check("post_rst_osc", 32'(osc_count), 32'd0);
    check("post_rst_trig", 32'(trig), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      run = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 49) == 0) step_len = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 59) == 0) last_step = 3'($urandom_range(0, 7));
      wr_bus.wr_en   = ($urandom_range(0, 3) == 0);
      wr_bus.wr_addr = 3'($urandom_range(0, 7));
      wr_bus.wr_data = 16'($urandom);
      tick_clk();
    end
    wr_bus.wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
